// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-4 butterfly stream.
package fft_pkg;

    typedef enum logic [0:0] {
        StLoad,
        StDrain
    } state_e;

    // Four-term complex sums need two guard bits above the input width.
    function automatic int unsigned out_width(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/butterfly_radix4_stream_if.sv
// Input/output stream signals of the radix-4 butterfly; the block itself is the slave.
interface butterfly_radix4_stream_if
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned OUT_W = out_width(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_re;
    logic [OUT_W-1:0]  out_im;
    logic              out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );

endinterface

// File: rtl/radix4_row.sv
// One radix-4 butterfly output row: selects the twiddle pattern for m, optional /4 scaling.
module radix4_row #(
    parameter int unsigned OUT_W = 18
) (
    input  logic signed [OUT_W-1:0] a_re,
    input  logic signed [OUT_W-1:0] a_im,
    input  logic signed [OUT_W-1:0] b_re,
    input  logic signed [OUT_W-1:0] b_im,
    input  logic signed [OUT_W-1:0] c_re,
    input  logic signed [OUT_W-1:0] c_im,
    input  logic signed [OUT_W-1:0] d_re,
    input  logic signed [OUT_W-1:0] d_im,
    input  logic        [1:0]       m,
    input  logic                    inverse,
    input  logic                    scale_en,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im
);

    logic        [1:0]       sel;
    logic signed [OUT_W-1:0] sum_re;
    logic signed [OUT_W-1:0] sum_im;

    // The inverse transform only flips the sign of j, which swaps rows 1 and 3.
    assign sel = (inverse && m[0]) ? (m ^ 2'b10) : m;

    always_comb begin
        sum_re = '0;
        sum_im = '0;
        unique case (sel)
            2'd0: begin
                sum_re = a_re + b_re + c_re + d_re;
                sum_im = a_im + b_im + c_im + d_im;
            end
            2'd1: begin
                sum_re = a_re + b_im - c_re - d_im;
                sum_im = a_im - b_re - c_im + d_re;
            end
            2'd2: begin
                sum_re = a_re - b_re + c_re - d_re;
                sum_im = a_im - b_im + c_im - d_im;
            end
            2'd3: begin
                sum_re = a_re - b_im - c_re + d_im;
                sum_im = a_im + b_re - c_im - d_re;
            end
            default: begin
                sum_re = '0;
                sum_im = '0;
            end
        endcase
    end

    assign y_re = scale_en ? (sum_re >>> 2) : sum_re;
    assign y_im = scale_en ? (sum_im >>> 2) : sum_im;

endmodule

// File: rtl/butterfly_radix4_stream.sv
// Streaming radix-4 butterfly: loads a frame of 4*Q samples, then drains 4*Q results in order.
module butterfly_radix4_stream
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned Q      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic inverse,
    input  logic scale_en,
    output logic busy,
    butterfly_radix4_stream_if.slave s
);

    localparam int unsigned     OUT_W   = out_width(DATA_W);
    localparam int unsigned     N       = 4 * Q;
    localparam int unsigned     CntW    = $clog2(N);
    localparam int unsigned     QW      = $clog2(Q);
    localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);
    localparam logic [CntW-1:0] QMask   = CntW'(Q - 1);

    logic [DATA_W-1:0] buf_re [N];
    logic [DATA_W-1:0] buf_im [N];

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              inv_q, inv_d;
    logic              scl_q, scl_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [OUT_W-1:0]  out_re_q, out_re_d;
    logic [OUT_W-1:0]  out_im_q, out_im_d;

    logic              in_fire;
    logic              out_adv;
    logic [CntW-1:0]   n_idx;
    logic [1:0]        m_sel;
    logic [OUT_W-1:0]  ext_re [4];
    logic [OUT_W-1:0]  ext_im [4];
    logic [OUT_W-1:0]  row_re;
    logic [OUT_W-1:0]  row_im;

    assign in_fire = en && s.in_valid && (state_q == StLoad);
    assign out_adv = en && (!out_valid_q || s.out_ready);

    // Output index i = n + Q*m; Q is a power of two so n and m are bit fields of cnt.
    assign n_idx = cnt_q & QMask;
    assign m_sel = 2'(cnt_q >> QW);

    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [CntW-1:0] idx;
        assign idx       = n_idx + CntW'(k * Q);
        assign ext_re[k] = OUT_W'($signed(buf_re[idx]));
        assign ext_im[k] = OUT_W'($signed(buf_im[idx]));
    end

    radix4_row #(
        .OUT_W (OUT_W)
    ) u_row (
        .a_re     (ext_re[0]),
        .a_im     (ext_im[0]),
        .b_re     (ext_re[1]),
        .b_im     (ext_im[1]),
        .c_re     (ext_re[2]),
        .c_im     (ext_im[2]),
        .d_re     (ext_re[3]),
        .d_im     (ext_im[3]),
        .m        (m_sel),
        .inverse  (inv_q),
        .scale_en (scl_q),
        .y_re     (row_re),
        .y_im     (row_im)
    );

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_re[cnt_q] <= s.in_re;
            buf_im[cnt_q] <= s.in_im;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        scl_d       = scl_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        unique case (state_q)
            StLoad: begin
                if (in_fire) begin
                    if (cnt_q == '0) begin
                        inv_d = inverse;
                        scl_d = scale_en;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_adv) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = StLoad;
                        cnt_d       = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_re_d    = row_re;
                        out_im_d    = row_im;
                        out_last_d  = (cnt_q == LastIdx);
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            scl_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            scl_q       <= scl_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign s.in_ready  = (state_q == StLoad);
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.out_re    = out_re_q;
    assign s.out_im    = out_im_q;
    assign busy        = !((state_q == StLoad) && (cnt_q == '0));

endmodule

// File: tb/tb_butterfly_radix4_stream.sv
// Directed bench for butterfly_radix4_stream (DATA_W=16, Q=4) with hand-computed results.
module tb_butterfly_radix4_stream;

    logic clk;
    logic rst;
    logic en;
    logic inverse;
    logic scale_en;
    logic busy;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0]        x_re [16];
    logic [15:0]        x_im [16];
    logic signed [17:0] exp_re [16];
    logic signed [17:0] exp_im [16];
    logic signed [17:0] got_re [16];
    logic signed [17:0] got_im [16];

    butterfly_radix4_stream_if #(.DATA_W(16)) bus ();

    butterfly_radix4_stream #(
        .DATA_W (16),
        .Q      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .inverse  (inverse),
        .scale_en (scale_en),
        .busy     (busy),
        .s        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int idx, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: impulse, 1: x0=1 x4=3 x12=1, 2: full-scale negative
    task automatic set_input(input int kind);
        for (int k = 0; k < 16; k++) begin
            x_re[k] = 16'd0;
            x_im[k] = 16'd0;
        end
        if (kind == 0) begin
            x_re[0] = 16'd1;
        end else if (kind == 1) begin
            x_re[0]  = 16'd1;
            x_re[4]  = 16'd3;
            x_re[12] = 16'd1;
        end else begin
            for (int k = 0; k < 16; k++) x_re[k] = 16'h8000;
        end
    endtask

    // kind 0: impulse, 1: fwd, 2: inverse, 3: fwd scaled, 4: full-scale
    task automatic set_exp(input int kind);
        for (int k = 0; k < 16; k++) begin
            exp_re[k] = '0;
            exp_im[k] = '0;
        end
        case (kind)
            0: begin
                exp_re[0] = 1; exp_re[4] = 1; exp_re[8] = 1; exp_re[12] = 1;
            end
            1: begin
                exp_re[0] = 5; exp_re[4] = 1; exp_im[4] = -2;
                exp_re[8] = -3; exp_re[12] = 1; exp_im[12] = 2;
            end
            2: begin
                exp_re[0] = 5; exp_re[4] = 1; exp_im[4] = 2;
                exp_re[8] = -3; exp_re[12] = 1; exp_im[12] = -2;
            end
            3: begin
                exp_re[0] = 1; exp_im[4] = -1; exp_re[8] = -1;
            end
            default: begin
                for (int k = 0; k < 4; k++) exp_re[k] = -131072;
            end
        endcase
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_re    = re;
        bus.in_im    = im;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 0, t, 0);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Modes are flipped after sample 0 to confirm they are captured only at frame start.
    task automatic send_frame(input logic inv, input logic scl, input bit quiet);
        inverse  = inv;
        scale_en = scl;
        for (int k = 0; k < 16; k++) begin
            push(x_re[k], x_im[k]);
            if (k == 0) begin
                inverse  = ~inv;
                scale_en = ~scl;
            end
            if (quiet) chk("quiet_out_valid", k, bus.out_valid, 0);
        end
    endtask

    task automatic collect(input bit bp);
        int n = 0;
        int cyc = 0;
        int lasts = 0;
        bit started = 0;
        bit prev_stall = 0;
        logic [17:0] prev_re = '0;
        logic [17:0] prev_im = '0;
        logic        prev_last = 1'b0;
        for (int t = 0; t < 400 && n < 16; t++) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", n, bus.out_valid, 1);
                chk("stall_re", n, bus.out_re, prev_re);
                chk("stall_im", n, bus.out_im, prev_im);
                chk("stall_last", n, bus.out_last, prev_last);
            end
            if (bus.out_valid) started = 1;
            if (started) cyc++;
            if (bus.out_valid && bus.out_ready) begin
                got_re[n] = bus.out_re;
                got_im[n] = bus.out_im;
                if (bus.out_last) lasts++;
                chk("out_last", n, bus.out_last, (n == 15) ? 1 : 0);
                n++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_re    = bus.out_re;
            prev_im    = bus.out_im;
            prev_last  = bus.out_last;
            step();
        end
        bus.out_ready = 1'b1;
        chk("out_count", 0, n, 16);
        chk("last_count", 0, lasts, 1);
        if (!bp) chk("full_rate_cycles", 0, cyc, 16);
        for (int k = n; k < 16; k++) begin
            got_re[k] = 'x;
            got_im[k] = 'x;
        end
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_re"}, k, got_re[k], exp_re[k]);
            chk({tag, "_im"}, k, got_im[k], exp_im[k]);
        end
        chk({tag, "_idle_busy"}, 0, busy, 0);
        chk({tag, "_idle_in_ready"}, 0, bus.in_ready, 1);
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        en            = 1'b1;
        inverse       = 1'b0;
        scale_en      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;

        repeat (2) step();
        rst = 1'b0;
        chk("rst_busy", 0, busy, 0);
        chk("rst_out_valid", 0, bus.out_valid, 0);
        chk("rst_out_last", 0, bus.out_last, 0);
        chk("rst_out_re", 0, bus.out_re, 0);
        chk("rst_out_im", 0, bus.out_im, 0);
        chk("rst_in_ready", 0, bus.in_ready, 1);

        // en low must block input acceptance
        en           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_re    = 16'd7;
        repeat (2) step();
        chk("en_off_busy", 0, busy, 0);
        bus.in_valid = 1'b0;
        en           = 1'b1;

        // Impulse: latency, en freeze on output, full-rate drain
        set_input(0);
        set_exp(0);
        send_frame(1'b0, 1'b0, 1'b0);
        chk("drain_out_valid", 0, bus.out_valid, 0);
        chk("drain_in_ready", 0, bus.in_ready, 0);
        chk("drain_busy", 0, busy, 1);
        step();
        chk("first_out_valid", 0, bus.out_valid, 1);
        chk("first_out_re", 0, bus.out_re, 1);
        en = 1'b0;
        repeat (3) step();
        chk("en_hold_valid", 0, bus.out_valid, 1);
        chk("en_hold_re", 0, bus.out_re, 1);
        chk("en_hold_last", 0, bus.out_last, 0);
        en = 1'b1;
        collect(1'b0);
        check_frame("impulse");

        // Forward frame
        set_input(1);
        set_exp(1);
        send_frame(1'b0, 1'b0, 1'b0);
        collect(1'b0);
        check_frame("fwd");

        // Inverse frame with junk in_valid during drain
        set_exp(2);
        send_frame(1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_re    = 16'h1234;
        bus.in_im    = 16'h4321;
        collect(1'b0);
        bus.in_valid = 1'b0;
        check_frame("inv");

        // Scaled forward
        set_exp(3);
        send_frame(1'b0, 1'b1, 1'b0);
        collect(1'b0);
        check_frame("scaled");

        // Full-scale negative input
        set_input(2);
        set_exp(4);
        send_frame(1'b0, 1'b0, 1'b0);
        collect(1'b0);
        check_frame("fullscale");

        // Random backpressure on the forward frame
        set_input(1);
        set_exp(1);
        send_frame(1'b0, 1'b0, 1'b0);
        collect(1'b1);
        check_frame("backpressure");

        // Reset after 7 inputs, then a clean frame
        set_input(2);
        for (int k = 0; k < 7; k++) push(x_re[k], x_im[k]);
        chk("partial_busy", 0, busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 0, busy, 0);
        chk("midrst_out_valid", 0, bus.out_valid, 0);
        set_input(1);
        set_exp(1);
        send_frame(1'b0, 1'b0, 1'b1);
        collect(1'b0);
        check_frame("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
